// File: rtl/fp4_fft_pkg.sv
// Shared definitions for the FP4 radix-2 DIT FFT datapath.
// FP4 E2M1 codes used by the twiddle ROM and AGU state encoding.
package fp4_fft_pkg;

  localparam logic [3:0] FP4_ZERO     = 4'b0000;
  localparam logic [3:0] FP4_HALF     = 4'b0001;
  localparam logic [3:0] FP4_ONE      = 4'b0010;
  localparam logic [3:0] FP4_NEG_HALF = 4'b1001;
  localparam logic [3:0] FP4_NEG_ONE  = 4'b1010;

  typedef enum logic {
    AGU_IDLE   = 1'b0,
    AGU_ACTIVE = 1'b1
  } agu_state_t;

endpackage

// File: rtl/fp4_twiddle_rom.sv
// FP4 twiddle ROM: W_MAX_N^k = cos - j*sin, quantised to {0, 0.5, 1}.
// Table is held at 64-point resolution and indexed by k scaled to it.
module fp4_twiddle_rom
  import fp4_fft_pkg::*;
#(
  parameter int MAX_N = 32,
  parameter int AW    = $clog2(MAX_N)
) (
  input  logic [AW-1:0] k,
  output logic [7:0]    twiddle
);

  logic [5:0] m;
  logic [3:0] re;
  logic [3:0] im;

  assign m = 6'(k) << (6 - AW);

  always_comb begin
    re = FP4_ZERO;
    case (m) inside
      [6'd0:6'd7]:   re = FP4_ONE;
      [6'd8:6'd13]:  re = FP4_HALF;
      [6'd14:6'd18]: re = FP4_ZERO;
      [6'd19:6'd24]: re = FP4_NEG_HALF;
      [6'd25:6'd31]: re = FP4_NEG_ONE;
      default:       re = FP4_ZERO;
    endcase
  end

  // imag is -sin, so the upper half-circle gives negative codes
  always_comb begin
    im = FP4_ZERO;
    case (m) inside
      [6'd0:6'd2]:   im = FP4_ZERO;
      [6'd3:6'd8]:   im = FP4_NEG_HALF;
      [6'd9:6'd23]:  im = FP4_NEG_ONE;
      [6'd24:6'd29]: im = FP4_NEG_HALF;
      default:       im = FP4_ZERO;
    endcase
  end

  assign twiddle = {re, im};

endmodule

// File: rtl/fp4_dit_agu.sv
// Butterfly address / twiddle generator for the FP4 radix-2 DIT FFT.
// Optional FFT_AGU_IFFT_EN adds an inv port for conjugate twiddles.
module fp4_dit_agu
  import fp4_fft_pkg::*;
#(
  parameter int MAX_N      = 32,
  parameter int ADDR_WIDTH = $clog2(MAX_N),
  parameter int LOG2W      = $clog2(ADDR_WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LOG2W-1:0]      cfg_log2n,
`ifdef FFT_AGU_IFFT_EN
  input  logic                  inv,
`endif
  input  logic                  next_step,
  output logic [ADDR_WIDTH-1:0] idx_a,
  output logic [ADDR_WIDTH-1:0] idx_b,
  output logic [ADDR_WIDTH-1:0] k,
  output logic [7:0]            twiddle_output,
  output logic                  done_stage,
  output logic                  done_fft,
  output logic [LOG2W-1:0]      curr_stage,
  output logic                  busy
);

  localparam logic [ADDR_WIDTH-1:0] ONES  = '1;
  localparam logic [ADDR_WIDTH-1:0] ONE_A = ADDR_WIDTH'(1);
  localparam logic [LOG2W-1:0]      L_MAX = LOG2W'(ADDR_WIDTH);
  localparam logic [LOG2W-1:0]      ONE_L = LOG2W'(1);

  agu_state_t state, state_n;
  logic [LOG2W-1:0]      l_q, l_n, s_q, s_n, l_cfg;
  logic [ADDR_WIDTH-1:0] b_q, b_n, b_last, mask, j, g;
  logic [ADDR_WIDTH-1:0] a_raw, k_int;
  logic                  ds_q, ds_n, primed_q, primed_n;
  logic                  active, stage_end, last_stage;
  logic [7:0]            tw_rom, tw_fix;

  assign l_cfg = (cfg_log2n == '0 || cfg_log2n > L_MAX)
               ? L_MAX : cfg_log2n;

  assign active     = (state == AGU_ACTIVE);
  assign b_last     = ONES >> (L_MAX - l_q + ONE_L);
  assign stage_end  = (b_q == b_last);
  assign last_stage = (s_q == l_q - ONE_L);

  // split flat counter into group g and in-group offset j
  assign mask  = ONES >> (L_MAX - s_q);
  assign j     = b_q & mask;
  assign g     = b_q >> s_q;
  assign a_raw = (g << (s_q + ONE_L)) | j;

  assign idx_a = active ? a_raw : '0;
  assign idx_b = active ? a_raw + (ONE_A << s_q) : '0;
  assign k_int = active ? j << (L_MAX - ONE_L - s_q) : '0;
  assign k     = k_int;

  assign curr_stage = active ? s_q : '0;
  assign busy       = active;
  assign done_stage = ds_q;
  assign done_fft   = active && last_stage && stage_end;

  fp4_twiddle_rom #(
    .MAX_N (MAX_N),
    .AW    (ADDR_WIDTH)
  ) u_rom (
    .k       (k_int),
    .twiddle (tw_rom)
  );

`ifdef FFT_AGU_IFFT_EN
  logic inv_q, inv_n;

  assign inv_n  = start ? inv : inv_q;
  assign tw_fix = (inv_q && tw_rom[3:0] != FP4_ZERO)
                ? {tw_rom[7:4], ~tw_rom[3], tw_rom[2:0]}
                : tw_rom;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) inv_q <= 1'b0;
    else     inv_q <= inv_n;
  end
`else
  assign tw_fix = tw_rom;
`endif

  // zero until the first run so reset leaves every output at 0
  assign twiddle_output = primed_q ? tw_fix : 8'h00;

  always_comb begin
    state_n  = state;
    l_n      = l_q;
    s_n      = s_q;
    b_n      = b_q;
    ds_n     = 1'b0;
    primed_n = primed_q;
    if (start) begin
      state_n  = AGU_ACTIVE;
      l_n      = l_cfg;
      s_n      = '0;
      b_n      = '0;
      primed_n = 1'b1;
    end else if (active && next_step) begin
      if (!stage_end) begin
        b_n = b_q + ONE_A;
      end else begin
        b_n  = '0;
        ds_n = 1'b1;
        if (last_stage) begin
          state_n = AGU_IDLE;
          s_n     = '0;
        end else begin
          s_n = s_q + ONE_L;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= AGU_IDLE;
      l_q      <= L_MAX;
      s_q      <= '0;
      b_q      <= '0;
      ds_q     <= 1'b0;
      primed_q <= 1'b0;
    end else begin
      state    <= state_n;
      l_q      <= l_n;
      s_q      <= s_n;
      b_q      <= b_n;
      ds_q     <= ds_n;
      primed_q <= primed_n;
    end
  end

endmodule

// File: tb/tb_fp4_dit_agu.sv
// Self-checking bench for fp4_dit_agu (MAX_N=32).
// Define FFT_AGU_IFFT_EN to also exercise the inverse twiddles.
module tb_fp4_dit_agu;

  typedef struct {
    logic [4:0] a;
    logic [4:0] b;
    logic [4:0] k;
    logic [7:0] tw;
    logic       ds;
    logic       ff;
    logic       busy;
    logic [2:0] st;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [2:0] cfg_log2n = 3'd0;
  logic       inv = 1'b0;
  logic       next_step = 1'b0;
  logic [4:0] idx_a, idx_b, k;
  logic [7:0] twiddle_output;
  logic       done_stage, done_fft, busy;
  logic [2:0] curr_stage;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];
  exp_t tab[13];

  always #5 clk = ~clk;

  fp4_dit_agu #(.MAX_N(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .cfg_log2n      (cfg_log2n),
`ifdef FFT_AGU_IFFT_EN
    .inv            (inv),
`endif
    .next_step      (next_step),
    .idx_a          (idx_a),
    .idx_b          (idx_b),
    .k              (k),
    .twiddle_output (twiddle_output),
    .done_stage     (done_stage),
    .done_fft       (done_fft),
    .curr_stage     (curr_stage),
    .busy           (busy)
  );

  function automatic exp_t mk(int a, int b, int kk, logic [7:0] tw,
                              logic ds, logic ff, logic bz, int st);
    exp_t e;
    e.a = 5'(a); e.b = 5'(b); e.k = 5'(kk); e.tw = tw;
    e.ds = ds; e.ff = ff; e.busy = bz; e.st = 3'(st);
    return e;
  endfunction

  function automatic logic [3:0] q4(real x);
    real ax;
    logic [3:0] m;
    ax = (x < 0.0) ? -x : x;
    if (ax < 0.25) return 4'b0000;
    m = (ax < 0.75) ? 4'b0001 : 4'b0010;
    return (x < 0.0) ? (m | 4'b1000) : m;
  endfunction

  function automatic logic [7:0] twm(int kk, logic iv);
    real th;
    th = 2.0 * 3.14159265358979 * real'(kk) / 32.0;
    return {q4($cos(th)), iv ? q4($sin(th)) : q4(-$sin(th))};
  endfunction

  task automatic check(string nm);
    exp_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL %s: scoreboard empty", nm);
      return;
    end
    e = sb.pop_front();
    if (idx_a !== e.a || idx_b !== e.b || k !== e.k ||
        twiddle_output !== e.tw || done_stage !== e.ds ||
        done_fft !== e.ff || busy !== e.busy || curr_stage !== e.st) begin
      n_bad++;
      $display("FAIL %s: got a=%0d b=%0d k=%0d tw=%h ds=%b ff=%b busy=%b st=%0d want a=%0d b=%0d k=%0d tw=%h ds=%b ff=%b busy=%b st=%0d",
               nm, idx_a, idx_b, k, twiddle_output, done_stage, done_fft,
               busy, curr_stage, e.a, e.b, e.k, e.tw, e.ds, e.ff,
               e.busy, e.st);
    end
  endtask

  task automatic cyc(logic st, logic ns, logic [2:0] cfg);
    @(negedge clk);
    start = st;
    next_step = ns;
    cfg_log2n = cfg;
    @(posedge clk);
    #1;
    start = 1'b0;
    next_step = 1'b0;
  endtask

  task automatic run_fft(logic [2:0] cfg, int l, logic step_too,
                         string nm);
    exp_t p[$];
    exp_t e;
    int half, total, ds_cnt, bf_cnt, kk;
    half = 1 << (l - 1);
    for (int s = 0; s < l; s++)
      for (int a = 0; a < (1 << l); a++)
        if (((a >> s) & 1) == 0) begin
          kk = (a & ((1 << s) - 1)) << (4 - s);
          p.push_back(mk(a, a + (1 << s), kk, twm(kk, inv),
                         1'b0, 1'b0, 1'b1, s));
        end
    total = p.size();
    ds_cnt = 0;
    bf_cnt = 0;
    sb.push_back(p[0]);
    cyc(1'b1, step_too, cfg);
    check({nm, "_start"});
    for (int i = 1; i <= total; i++) begin
      if (i < total) e = p[i];
      else e = mk(0, 0, 0, 8'h20, 1'b0, 1'b0, 1'b0, 0);
      e.ds = (i % half == 0);
      e.ff = (i == total - 1);
      sb.push_back(e);
      bf_cnt += busy ? 1 : 0;
      cyc(1'b0, 1'b1, cfg);
      ds_cnt += done_stage ? 1 : 0;
      check(nm);
    end
    n_cmp++;
    if (bf_cnt != total || ds_cnt != l) begin
      n_bad++;
      $display("FAIL %s_counts: got bfly=%0d ds=%0d want bfly=%0d ds=%0d",
               nm, bf_cnt, ds_cnt, total, l);
    end
  endtask

  initial begin
    int pa[12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    int kt[12] = '{0, 0, 0, 0, 0, 8, 0, 8, 0, 4, 8, 12};
    logic [7:0] tt[12] = '{8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h0A,
                           8'h20, 8'h0A, 8'h20, 8'h19, 8'h0A, 8'h99};
    for (int i = 0; i < 12; i++)
      tab[i] = mk(pa[i], pa[i] + (1 << (i / 4)), kt[i], tt[i],
                  (i == 4 || i == 8), (i == 11), 1'b1, i / 4);
    tab[12] = mk(0, 0, 0, 8'h20, 1'b1, 1'b0, 1'b0, 0);

    #12;
    sb.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 0));
    check("reset");
    @(negedge clk);
    rst = 1'b0;
    sb.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 0));
    cyc(1'b0, 1'b1, 3'd3);
    check("idle_step_after_reset");

    sb.push_back(tab[0]);
    cyc(1'b1, 1'b0, 3'd3);
    check("n8_start");
    for (int i = 1; i <= 12; i++) begin
      sb.push_back(tab[i]);
      cyc(1'b0, 1'b1, 3'd3);
      check($sformatf("n8_step%0d", i));
    end
    sb.push_back(mk(0, 0, 0, 8'h20, 0, 0, 0, 0));
    cyc(1'b0, 1'b0, 3'd3);
    check("n8_idle");
    sb.push_back(mk(0, 0, 0, 8'h20, 0, 0, 0, 0));
    cyc(1'b0, 1'b1, 3'd3);
    check("n8_idle_step_ignored");

    sb.push_back(tab[0]);
    cyc(1'b1, 1'b0, 3'd3);
    check("rst_run_start");
    for (int i = 1; i <= 3; i++) begin
      sb.push_back(tab[i]);
      cyc(1'b0, 1'b1, 3'd3);
      check("rst_run_step");
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    sb.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 0));
    check("reset_mid_run");
    @(negedge clk);
    rst = 1'b0;
    sb.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 0));
    cyc(1'b0, 1'b1, 3'd3);
    check("idle_after_mid_reset");

    sb.push_back(tab[0]);
    cyc(1'b1, 1'b0, 3'd3);
    check("abort_n8_start");
    for (int i = 1; i <= 5; i++) begin
      sb.push_back(tab[i]);
      cyc(1'b0, 1'b1, 3'd3);
      check("abort_n8_step");
    end
    run_fft(3'd5, 5, 1'b1, "abort_n32");
    run_fft(3'd0, 5, 1'b0, "clamp0");
    run_fft(3'd7, 5, 1'b0, "clamp7");
    run_fft(3'd2, 2, 1'b0, "n4");
`ifdef FFT_AGU_IFFT_EN
    inv = 1'b1;
    run_fft(3'd5, 5, 1'b0, "ifft_n32");
    inv = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fp4_dit_agu.md
Name: fp4_dit_agu

Overview:
Address Generation Unit (AGU) for the FP4 radix-2 DIT FFT. It is the responder side of the core/AGU handshake:
- Presents butterfly indices idx_a/idx_b, twiddle index k and the FP4 complex twiddle for the current butterfly.
- Advances one butterfly per next_step pulse.
- Flags stage completion (used for ping-pong bank swap) and last-butterfly (used by the core's UPDATE_AGU decision).

Parameters:
MAX_N, 32, largest supported FFT size (power of two, 4..64)
ADDR_WIDTH, $clog2(MAX_N), sample address width
LOG2W, $clog2(ADDR_WIDTH+1), width of stage/size fields

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse: latch cfg_log2n, clear counters, go ACTIVE
cfg_log2n  in  LOG2W  log2 of FFT size for this run; 0 or >ADDR_WIDTH clamps to ADDR_WIDTH
next_step  in  1  core request: advance to next butterfly
idx_a  out  ADDR_WIDTH  upper butterfly input/output address
idx_b  out  ADDR_WIDTH  lower address = idx_a + 2^stage
k  out  ADDR_WIDTH  twiddle index in MAX_N units
twiddle_output  out  8  FP4 complex W_MAX_N^k: [7:4] real, [3:0] imag, E2M1 each
done_stage  out  1  one-cycle pulse after the next_step that completes a stage
done_fft  out  1  high while ACTIVE and the final butterfly of the final stage is presented
curr_stage  out  LOG2W  current stage 0..L-1
busy  out  1  high in ACTIVE

Behaviour:
- States IDLE, ACTIVE. Reset → IDLE; all outputs 0 (idx_a=idx_b=k=0, twiddle_output=8'h00, flags 0).
- Registers: L (latched size), stage s, flat butterfly counter b in 0..2^(L-1)-1.
- Combinational from registers:
  - j = b & (2^s - 1); g = b >> s
  - idx_a = (g << (s+1)) | j; idx_b = idx_a + 2^s
  - k = j << (ADDR_WIDTH-1-s)
  - twiddle_output = ROM[k]
- Outputs are valid the cycle after start and the cycle after each accepted next_step; there is zero-latency lookup from counter state.
- IDLE + start → ACTIVE, s=0, b=0. next_step is ignored in IDLE.
- ACTIVE + next_step:
  - If b < 2^(L-1)-1: b++.
  - Otherwise b=0, done_stage pulses next cycle, and:
    - if s < L-1: s++
    - if s = L-1: → IDLE
- done_fft = ACTIVE && s==L-1 && b==2^(L-1)-1. It is combinational on registers and is sampled by the core in the same cycle it asserts next_step.
- start while ACTIVE: abort and restart at s=0,b=0 with new cfg; no done_stage pulse. start and next_step in the same cycle: start wins.
- Reset mid-run: immediate return to IDLE, all outputs 0.
- In IDLE, idx_a/idx_b/k/curr_stage hold 0 and twiddle_output = ROM[0].
- ROM holds MAX_N/2 entries of W^k = cos(2πk/MAX_N) − j·sin(2πk/MAX_N), quantised per component:
  - |x| < 0.25 → 0
  - |x| < 0.75 → 0.5
  - otherwise → 1.0
  - Sign bit is applied only to nonzero values (no −0).
- Encodings: 0=4'b0000, 0.5=4'b0001, 1.0=4'b0010, −0.5=4'b1001, −1.0=4'b1010.

Optional Feature:
FFT_AGU_IFFT_EN
- Defined: adds input port inv (1 bit), latched on start. When the latched value is 1, the imag sign bit of twiddle_output is inverted for nonzero imag (conjugate twiddle, inverse FFT).
- Undefined: no inv port; forward twiddles only.

Decomposition:
- Package fp4_fft_pkg: FP4 E2M1 codes (FP4_ZERO, FP4_HALF, FP4_ONE, FP4_NEG_HALF, FP4_NEG_ONE) and AGU state encodings.
- Sub-module fp4_twiddle_rom (param MAX_N; input k, output 8-bit twiddle; combinational case table).

Test Plan:
- Reset: rst=1 mid-run → all outputs 0, busy=0; next_step pulses in IDLE → no change.
- N=8 (cfg_log2n=3), pulse next_step 12 times:
  - stage 0 pairs: (0,1),(2,3),(4,5),(6,7), k=0
  - stage 1: (0,2),(1,3),(4,6),(5,7), k=0,8,0,8
  - stage 2: (0,4),(1,5),(2,6),(3,7), k=0,4,8,12
  - done_stage after pulses 4, 8 and 12
- Twiddles at MAX_N=32: k=0 → 8'h20, k=4 → 8'h19, k=8 → 8'h0A, k=12 → 8'h99.
- done_fft: high only while (3,7) is presented at N=8; the next next_step → busy=0, done_fft=0, one final done_stage pulse.
- Abort: start during stage 1 with cfg_log2n=5 → next cycle s=0, b=0, idx (0,1), no done_stage; full N=32 run yields 80 butterflies and 5 done_stage pulses.
- Clamp and optional feature:
  - cfg_log2n=0 → behaves as N=32.
  - With FFT_AGU_IFFT_EN and inv=1: k=8 → 8'h02, k=0 → 8'h20.
